// File: rtl/hyperram_seq_pkg.sv
// Shared types and constants for the HyperRAM bring-up sequencer.
// Holds the FSM state encoding, the lock-stability window and the retry counter width.
package hyperram_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_PLL_RST   = 3'd1,
      ST_WAIT_LOCK = 3'd2,
      ST_PWRUP     = 3'd3,
      ST_READY     = 3'd4,
      ST_FAIL      = 3'd5
   } state_t;

   localparam int LOCK_STABLE_CYCLES = 8;
   localparam int STAB_W             = $clog2(LOCK_STABLE_CYCLES);
   localparam int RETRY_W            = 2;

   // Counter only ever holds 0..N-1 for the largest phase length, so clog2(N) bits suffice.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Two-flop synchronizer for a single asynchronous level signal.
// Both flops clear on the synchronous reset so a stale lock cannot leak through.
module cdc_sync_bit (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/hyperram_init_sequencer.sv
// Brings up the HyperRAM clocking path: PLL reset pulse, lock qualification with retries,
// power-up wait, then releases the controller AXI reset; drops back to PLL reset on lock loss.
module hyperram_init_sequencer
   import hyperram_seq_pkg::*;
#(
   parameter int PLL_RST_CYCLES = 16,
   parameter int LOCK_TIMEOUT   = 65535,
   parameter int PWRUP_CYCLES   = 30000,
   parameter int MAX_RETRIES    = 3
) (
   input  logic               hclk,
   input  logic               hreset,
   input  logic               enable,
   input  logic               clk_90p_locked,
   input  logic               clk_iserdes_locked,
   output logic               pll_reset,
   output logic               axi_aresetn,
   output logic               ready,
   output logic               error,
   output logic [RETRY_W-1:0] retries,
   output logic               lock_lost,
   output state_t             o_dbg_state
);

   localparam int CNT_W = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, PWRUP_CYCLES);

   localparam logic [CNT_W-1:0]   PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0]   LOCK_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]   PWRUP_LAST   = CNT_W'(PWRUP_CYCLES - 1);
   localparam logic [STAB_W-1:0]  STAB_LAST    = STAB_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_LAST   = RETRY_W'(MAX_RETRIES - 1);

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [STAB_W-1:0]  r_stab;
   logic               r_en_q;
   logic               r_pll_reset;
   logic               r_aresetn;
   logic               r_ready;
   logic               r_error;
   logic [RETRY_W-1:0] r_retries;
   logic               r_lock_lost;

   logic w_sync_90p;
   logic w_sync_iserdes;
   logic w_locked;
   logic w_en_rise;

   cdc_sync_bit u_sync_90p (
      .i_clk (hclk),
      .i_rst (hreset),
      .i_d   (clk_90p_locked),
      .o_q   (w_sync_90p)
   );

   cdc_sync_bit u_sync_iserdes (
      .i_clk (hclk),
      .i_rst (hreset),
      .i_d   (clk_iserdes_locked),
      .o_q   (w_sync_iserdes)
   );

   assign w_locked  = w_sync_90p & w_sync_iserdes;
   assign w_en_rise = enable & ~r_en_q;

   always_ff @(posedge hclk) begin
      if (hreset) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_stab      <= '0;
         r_en_q      <= 1'b0;
         r_pll_reset <= 1'b1;
         r_aresetn   <= 1'b0;
         r_ready     <= 1'b0;
         r_error     <= 1'b0;
         r_retries   <= '0;
         r_lock_lost <= 1'b0;
      end else begin
         r_en_q <= enable;
         // lock_lost survives a disable so software can still read why the path went down
         if (w_en_rise) r_lock_lost <= 1'b0;

         if (!enable) begin
            // Disable outranks every other event, including a simultaneous lock drop
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_stab      <= '0;
            r_pll_reset <= 1'b1;
            r_aresetn   <= 1'b0;
            r_ready     <= 1'b0;
            r_error     <= 1'b0;
            r_retries   <= '0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  r_state     <= ST_PLL_RST;
                  r_cnt       <= '0;
                  r_pll_reset <= 1'b1;
               end

               ST_PLL_RST: begin
                  if (r_cnt == PLL_RST_LAST) begin
                     r_state     <= ST_WAIT_LOCK;
                     r_cnt       <= '0;
                     r_stab      <= '0;
                     r_pll_reset <= 1'b0;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end

               ST_WAIT_LOCK: begin
                  if (w_locked && (r_stab == STAB_LAST)) begin
                     r_state <= ST_PWRUP;
                     r_cnt   <= '0;
                     r_stab  <= '0;
                  end else if (r_cnt == LOCK_LAST) begin
                     r_retries   <= r_retries + 1'b1;
                     r_cnt       <= '0;
                     r_stab      <= '0;
                     r_pll_reset <= 1'b1;
                     if (r_retries == RETRY_LAST) begin
                        r_state <= ST_FAIL;
                        r_error <= 1'b1;
                     end else begin
                        r_state <= ST_PLL_RST;
                     end
                  end else begin
                     r_cnt  <= r_cnt + 1'b1;
                     r_stab <= w_locked ? (r_stab + 1'b1) : '0;
                  end
               end

               ST_PWRUP: begin
                  if (!w_locked) begin
                     r_state     <= ST_PLL_RST;
                     r_cnt       <= '0;
                     r_pll_reset <= 1'b1;
                  end else if (r_cnt == PWRUP_LAST) begin
                     r_state   <= ST_READY;
                     r_cnt     <= '0;
                     r_aresetn <= 1'b1;
                     r_ready   <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end

               ST_READY: begin
                  if (!w_locked) begin
                     r_state     <= ST_PLL_RST;
                     r_cnt       <= '0;
                     r_pll_reset <= 1'b1;
                     r_aresetn   <= 1'b0;
                     r_ready     <= 1'b0;
                     r_lock_lost <= 1'b1;
                     r_retries   <= '0;
                  end
               end

               ST_FAIL: begin
                  r_error     <= 1'b1;
                  r_pll_reset <= 1'b1;
                  r_aresetn   <= 1'b0;
                  r_ready     <= 1'b0;
               end

               default: begin
                  r_state     <= ST_IDLE;
                  r_cnt       <= '0;
                  r_pll_reset <= 1'b1;
                  r_aresetn   <= 1'b0;
                  r_ready     <= 1'b0;
               end
            endcase
         end
      end
   end

   assign pll_reset   = r_pll_reset;
   assign axi_aresetn = r_aresetn;
   assign ready       = r_ready;
   assign error       = r_error;
   assign retries     = r_retries;
   assign lock_lost   = r_lock_lost;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_hyperram_init_sequencer.sv
// Directed bench for the HyperRAM bring-up sequencer: expected output snapshots are queued
// with the cycle they apply to, and a monitor compares them on the falling edge.
module tb_hyperram_init_sequencer;
   import hyperram_seq_pkg::*;

   localparam int PLL_RST_CYCLES = 4;
   localparam int LOCK_TIMEOUT   = 20;
   localparam int PWRUP_CYCLES   = 10;
   localparam int MAX_RETRIES    = 2;

   logic       hclk = 1'b0;
   logic       hreset;
   logic       enable;
   logic       clk_90p_locked;
   logic       clk_iserdes_locked;
   logic       pll_reset;
   logic       axi_aresetn;
   logic       ready;
   logic       error;
   logic [1:0] retries;
   logic       lock_lost;
   state_t     dbg_state;

   // Output snapshot order: pll_reset, axi_aresetn, ready, error, retries[1:0], lock_lost
   typedef struct packed {
      int           cyc;
      logic [127:0] name;
      logic [6:0]   val;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       mon_e;
   logic [6:0] act;
   int         cyc      = 0;
   int         n_checks = 0;
   int         n_errors = 0;
   int         t0;

   hyperram_init_sequencer #(
      .PLL_RST_CYCLES (PLL_RST_CYCLES),
      .LOCK_TIMEOUT   (LOCK_TIMEOUT),
      .PWRUP_CYCLES   (PWRUP_CYCLES),
      .MAX_RETRIES    (MAX_RETRIES)
   ) dut (
      .hclk               (hclk),
      .hreset             (hreset),
      .enable             (enable),
      .clk_90p_locked     (clk_90p_locked),
      .clk_iserdes_locked (clk_iserdes_locked),
      .pll_reset          (pll_reset),
      .axi_aresetn        (axi_aresetn),
      .ready              (ready),
      .error              (error),
      .retries            (retries),
      .lock_lost          (lock_lost),
      .o_dbg_state        (dbg_state)
   );

   // clock / cycle counter: after rising edge n, cyc == n
   always #5 hclk = ~hclk;
   always @(posedge hclk) cyc <= cyc + 1;

   assign act = {pll_reset, axi_aresetn, ready, error, retries, lock_lost};

   function automatic logic [6:0] ov(input logic pr, input logic an, input logic rd,
                                     input logic er, input logic [1:0] rt, input logic ll);
      return {pr, an, rd, er, rt, ll};
   endfunction

   task automatic chk(input int at, input logic [127:0] nm, input logic [6:0] v);
      exp_t e;
      e.cyc  = at;
      e.name = nm;
      e.val  = v;
      exp_q.push_back(e);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge hclk);
   endtask

   // monitor / scoreboard
   always @(negedge hclk) begin
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         mon_e = exp_q.pop_front();
         n_checks++;
         if (mon_e.cyc != cyc || act !== mon_e.val) begin
            n_errors++;
            $display("FAIL %0s cycle %0d: got %b required %b (pll_reset,aresetn,ready,error,retries,lock_lost)",
                     mon_e.name, mon_e.cyc, act, mon_e.val);
         end
      end
   end

   initial begin
      hreset             = 1'b1;
      enable             = 1'b0;
      clk_90p_locked     = 1'b0;
      clk_iserdes_locked = 1'b0;
      @(negedge hclk);
      chk(3, "reset_state", ov(1, 0, 0, 0, 2'd0, 0));
      wait_until(3);
      n_checks++;
      if (act !== 7'b1000000) begin
         n_errors++;
         $display("FAIL direct_reset_outputs: got %b", act);
      end
      n_checks++;
      if (dbg_state !== ST_IDLE) begin
         n_errors++;
         $display("FAIL direct_reset_state: got %0d", dbg_state);
      end
      hreset = 1'b0;

      // Nominal bring-up: enable at t0, both locks at t0+6; 2 sync + 8 stable + 10 power-up edges
      t0 = cyc;
      enable = 1'b1;
      chk(t0 + 1,  "pllrst_entry",   ov(1, 0, 0, 0, 2'd0, 0));
      chk(t0 + 4,  "pllrst_hold",    ov(1, 0, 0, 0, 2'd0, 0));
      chk(t0 + 5,  "pllrst_release", ov(0, 0, 0, 0, 2'd0, 0));
      chk(t0 + 25, "nom_pre_ready",  ov(0, 0, 0, 0, 2'd0, 0));
      chk(t0 + 26, "nom_ready",      ov(0, 1, 1, 0, 2'd0, 0));
      wait_until(t0 + 6);
      clk_90p_locked     = 1'b1;
      clk_iserdes_locked = 1'b1;
      wait_until(t0 + 30);
      n_checks++;
      if (dbg_state !== ST_READY || ready !== 1'b1) begin
         n_errors++;
         $display("FAIL direct_nom_ready: state %0d ready %b", dbg_state, ready);
      end

      // Lock loss while ready, then re-lock
      t0 = cyc;
      clk_iserdes_locked = 1'b0;
      chk(t0 + 2,  "loss_still_ready", ov(0, 1, 1, 0, 2'd0, 0));
      chk(t0 + 3,  "loss_drop",        ov(1, 0, 0, 0, 2'd0, 1));
      chk(t0 + 6,  "loss_pll_hold",    ov(1, 0, 0, 0, 2'd0, 1));
      chk(t0 + 7,  "loss_pll_release", ov(0, 0, 0, 0, 2'd0, 1));
      chk(t0 + 24, "relock_pre_ready", ov(0, 0, 0, 0, 2'd0, 1));
      chk(t0 + 25, "relock_ready",     ov(0, 1, 1, 0, 2'd0, 1));
      wait_until(t0 + 3);
      clk_iserdes_locked = 1'b1;
      wait_until(t0 + 27);

      // Disable keeps lock_lost; the next enable rise clears it
      t0 = cyc;
      enable             = 1'b0;
      clk_90p_locked     = 1'b0;
      clk_iserdes_locked = 1'b0;
      chk(t0 + 1, "disable_keeps_lost", ov(1, 0, 0, 0, 2'd0, 1));
      wait_until(t0 + 3);

      // One-cycle lock glitch inside the stability window delays ready by 5
      t0 = cyc;
      enable = 1'b1;
      chk(t0 + 1,  "lost_cleared",     ov(1, 0, 0, 0, 2'd0, 0));
      chk(t0 + 30, "glitch_pre_ready", ov(0, 0, 0, 0, 2'd0, 0));
      chk(t0 + 31, "glitch_ready",     ov(0, 1, 1, 0, 2'd0, 0));
      wait_until(t0 + 6);
      clk_90p_locked     = 1'b1;
      clk_iserdes_locked = 1'b1;
      wait_until(t0 + 10);
      clk_iserdes_locked = 1'b0;
      wait_until(t0 + 11);
      clk_iserdes_locked = 1'b1;
      wait_until(t0 + 33);

      // Enable low and lock low seen on the same edge: disable wins, lock_lost not set
      t0 = cyc;
      clk_iserdes_locked = 1'b0;
      chk(t0 + 2, "prio_ready_before", ov(0, 1, 1, 0, 2'd0, 0));
      chk(t0 + 3, "prio_enable_wins",  ov(1, 0, 0, 0, 2'd0, 0));
      chk(t0 + 6, "prio_stays_idle",   ov(1, 0, 0, 0, 2'd0, 0));
      wait_until(t0 + 2);
      enable = 1'b0;
      wait_until(t0 + 6);

      // Disable during power-up
      t0 = cyc;
      enable             = 1'b1;
      clk_iserdes_locked = 1'b1;
      chk(t0 + 13, "pwrup_entry",       ov(0, 0, 0, 0, 2'd0, 0));
      chk(t0 + 17, "pwrup_still",       ov(0, 0, 0, 0, 2'd0, 0));
      chk(t0 + 18, "disable_pwrup",     ov(1, 0, 0, 0, 2'd0, 0));
      chk(t0 + 19, "disable_idle_hold", ov(1, 0, 0, 0, 2'd0, 0));
      wait_until(t0 + 17);
      enable = 1'b0;
      wait_until(t0 + 20);

      // Lock never arrives: two timeouts then FAIL
      t0 = cyc;
      clk_90p_locked     = 1'b0;
      clk_iserdes_locked = 1'b0;
      wait_until(t0 + 3);
      t0 = cyc;
      enable = 1'b1;
      chk(t0 + 5,  "to_wait_lock",   ov(0, 0, 0, 0, 2'd0, 0));
      chk(t0 + 24, "to_pre_timeout", ov(0, 0, 0, 0, 2'd0, 0));
      chk(t0 + 25, "timeout1",       ov(1, 0, 0, 0, 2'd1, 0));
      chk(t0 + 29, "retry_wait",     ov(0, 0, 0, 0, 2'd1, 0));
      chk(t0 + 48, "retry_pre_fail", ov(0, 0, 0, 0, 2'd1, 0));
      chk(t0 + 49, "fail",           ov(1, 0, 0, 1, 2'd2, 0));
      chk(t0 + 60, "fail_hold",      ov(1, 0, 0, 1, 2'd2, 0));
      wait_until(t0 + 60);
      n_checks++;
      if (dbg_state !== ST_FAIL) begin
         n_errors++;
         $display("FAIL direct_fail_state: got %0d", dbg_state);
      end
      n_checks++;
      if (error !== 1'b1) begin
         n_errors++;
         $display("FAIL direct_fail_error: got %b", error);
      end
      enable = 1'b0;
      chk(t0 + 61, "fail_exit",      ov(1, 0, 0, 0, 2'd0, 0));
      wait_until(t0 + 63);

      // hreset during the second lock attempt aborts on the same edge
      t0 = cyc;
      enable = 1'b1;
      chk(t0 + 30, "wl_before_reset", ov(0, 0, 0, 0, 2'd1, 0));
      chk(t0 + 31, "reset_abort",     ov(1, 0, 0, 0, 2'd0, 0));
      chk(t0 + 32, "reset_hold",      ov(1, 0, 0, 0, 2'd0, 0));
      chk(t0 + 33, "restart_pllrst",  ov(1, 0, 0, 0, 2'd0, 0));
      chk(t0 + 37, "restart_wait",    ov(0, 0, 0, 0, 2'd0, 0));
      wait_until(t0 + 30);
      hreset = 1'b1;
      wait_until(t0 + 32);
      hreset = 1'b0;
      wait_until(t0 + 40);
      n_checks++;
      if (dbg_state !== ST_WAIT_LOCK) begin
         n_errors++;
         $display("FAIL direct_restart_state: got %0d", dbg_state);
      end

      // final report
      while (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         n_checks++;
         n_errors++;
         $display("FAIL %0s cycle %0d: never compared, required %b", mon_e.name, mon_e.cyc, mon_e.val);
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/hyperram_init_sequencer.md
HYPERRAM_INIT_SEQUENCER -- requirements
Module: hyperram_init_sequencer

Interface
REQ-001 The block SHALL have parameter PLL_RST_CYCLES, default 16: number of cycles pll_reset is held high per attempt (minimum 1).
REQ-002 The block SHALL have parameter LOCK_TIMEOUT, default 65535: maximum cycles spent waiting for both PLLs to lock per attempt.
REQ-003 The block SHALL have parameter PWRUP_CYCLES, default 30000: HyperRAM power-up wait (150 us at 200 MHz) before the AXI reset is released.
REQ-004 The block SHALL have parameter MAX_RETRIES, default 3 (range 1..3): number of lock attempts before failure.
REQ-005 The block SHALL have port hclk, input, 1 bit: the single clock.
REQ-006 The block SHALL have port hreset, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port enable, input, 1 bit: level request to bring up the HyperRAM path.
REQ-008 The block SHALL have port clk_90p_locked, input, 1 bit: 90-degree PLL lock (asynchronous).
REQ-009 The block SHALL have port clk_iserdes_locked, input, 1 bit: ISERDES PLL lock (asynchronous).
REQ-010 The block SHALL have port pll_reset, output, 1 bit: drives the RST input of both PLLs.
REQ-011 The block SHALL have port axi_aresetn, output, 1 bit: drives the controller's s_axi_aresetn.
REQ-012 The block SHALL have port ready, output, 1 bit: HyperRAM path is usable.
REQ-013 The block SHALL have port error, output, 1 bit: bring-up failed.
REQ-014 The block SHALL have port retries, output, 2 bits: failed lock attempts in the current bring-up.
REQ-015 The block SHALL have port lock_lost, output, 1 bit: sticky flag, lock dropped while ready.

Function
REQ-016 Both lock inputs SHALL pass through 2-flop synchronizers; "locked" SHALL mean both synchronized lock signals are high.
REQ-017 The FSM SHALL have states IDLE, PLL_RST, WAIT_LOCK, PWRUP, READY and FAIL; all outputs SHALL be registered.
REQ-018 In IDLE: pll_reset=1, axi_aresetn=0, ready=0; when enable=1, the FSM SHALL go to PLL_RST and clear the counter.
REQ-019 In PLL_RST: pll_reset=1 for exactly PLL_RST_CYCLES cycles, then the FSM SHALL go to WAIT_LOCK.
REQ-020 In WAIT_LOCK: pll_reset=0; when locked has been high for 8 consecutive cycles, the FSM SHALL go to PWRUP; any low sample SHALL restart the stability count.
REQ-021 In WAIT_LOCK, when the cycle count reaches LOCK_TIMEOUT: retries SHALL increment; if retries+1 == MAX_RETRIES the FSM SHALL go to FAIL, else to PLL_RST.
REQ-022 In PWRUP: axi_aresetn=0 for PWRUP_CYCLES cycles, then the FSM SHALL go to READY; loss of lock SHALL go to PLL_RST without incrementing retries.
REQ-023 In READY: axi_aresetn=1, ready=1.
REQ-024 In READY, loss of lock SHALL drive axi_aresetn=0 and ready=0 on the next edge, set lock_lost, clear retries and go to PLL_RST.
REQ-025 In FAIL: error=1, pll_reset=1, axi_aresetn=0; the FSM SHALL hold until enable=0.
REQ-026 enable=0 in any non-IDLE state SHALL go to IDLE on the next edge and clear retries and error; lock_lost SHALL clear only on the next enable rising edge.
REQ-027 If enable falls and lock drops in the same cycle, enable SHALL take priority (IDLE).
REQ-028 The counter SHALL be wide enough for max(LOCK_TIMEOUT, PWRUP_CYCLES) and SHALL never wrap.

Reset
REQ-029 On hreset the block SHALL set state=IDLE, pll_reset=1, axi_aresetn=0, ready=0, error=0, retries=0, lock_lost=0, counters=0 and synchronizers=0.
REQ-030 hreset asserted mid-sequence SHALL abort on the same edge, with no partial outputs afterwards.

Structure
REQ-031 Package hyperram_seq_pkg SHALL hold the state enum, the lock-stability constant (8) and the retries width.
REQ-032 The lock synchronizer SHALL be one sub-module, cdc_sync_bit, instantiated twice.

Verification
Bench parameters: PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, PWRUP_CYCLES=10, MAX_RETRIES=2.

REQ-033 Nominal bring-up: enable=1 at cycle 0, both locks high from cycle 6 -> pll_reset low after 4 cycles; ready=1 and axi_aresetn=1 exactly 2+8+10 cycles after locks rise (plus 1 register).
REQ-034 Lock never asserts -> two timeouts; retries 1 then 2; error=1 after about 2x(4+20) cycles; pll_reset=1; ready=0.
REQ-035 Lock glitches low 1 cycle during stability window -> stability count restarts; ready delayed by the same amount; retries stays 0.
REQ-036 In READY, clk_iserdes_locked drops -> axi_aresetn=0 within 3 cycles, lock_lost=1, pll_reset pulses 4 cycles; re-lock -> ready=1 again, lock_lost stays 1.
REQ-037 enable=0 during PWRUP and hreset during WAIT_LOCK -> IDLE next edge with every output at its reset value.
